// File: rtl/uart_recv.sv
// uart_recv: 8N1 serial receiver; mid-bit sampling, start-glitch rejection,
// framing-error detection and break handling, one-cycle valid/frame_err strobes.
module uart_recv #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FIRST = CW'(CLKS_PER_BIT > 1 ? 1 : 0);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t r_state;
  logic r_s1, r_s2;
  logic [CW-1:0] r_cyc;
  logic [2:0] r_idx;
  logic [7:0] r_sh;
  logic w_mid, w_end;
  assign w_mid = r_cyc == HALF;
  assign w_end = r_cyc == LAST;
  // The detection cycle is cyc 0 of the start bit, so the counter resumes at 1.
  // With one clock per bit the detection cycle is also the start-bit sample.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_state   <= IDLE;
      r_cyc     <= '0;
      r_idx     <= '0;
      r_sh      <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_s1      <= rxd;
      r_s2      <= r_s1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      r_cyc     <= (r_state == IDLE) ? FIRST : (w_end ? '0 : r_cyc + 1'b1);
      case (r_state)
        IDLE:
          if (!r_s2) begin
            r_state <= (CLKS_PER_BIT == 1) ? DATA : START;
            r_idx   <= '0;
            busy    <= 1'b1;
          end
        START:
          if (w_mid && r_s2) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else if (w_end)
            r_state <= DATA;
        DATA: begin
          if (w_mid) r_sh <= {r_s2, r_sh[7:1]};
          if (w_end) begin
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= STOP;
          end
        end
        STOP:
          if (w_mid) begin
            if (r_s2) begin
              dout    <= r_sh;
              valid   <= 1'b1;
              busy    <= 1'b0;
              r_state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= BREAK;
            end
          end
        BREAK:
          if (r_s2) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: drives directed frames into three receivers (1, 4, 16 clocks/bit)
// and checks every output each cycle against a per-cycle expectation timeline.
module tb_uart_recv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rxd = '1;
  logic [2:0][7:0] dout;
  logic [2:0] valid, ferr, busy;
  int t = 0;
  int n_vec = 0, n_err = 0;
  int cpb[3] = '{1, 4, 16};
  int jt[10] = '{0, 3, -3, 2, -2, 1, -1, 3, -3, 2};
  bit ev_v[3][4096];
  bit ev_f[3][4096];
  bit ev_b[3][4096];
  logic [7:0] ev_d[3][4096];
  logic [7:0] cur[3] = '{8'h00, 8'h00, 8'h00};
  int vt[3], vp[3], vc[3], fc[3];
  logic [7:0] vd[3];

  uart_recv #(.CLKS_PER_BIT(1)) u0 (.clk(clk), .rst(rst), .rxd(rxd[0]), .dout(dout[0]),
    .valid(valid[0]), .frame_err(ferr[0]), .busy(busy[0]));
  uart_recv #(.CLKS_PER_BIT(4)) u1 (.clk(clk), .rst(rst), .rxd(rxd[1]), .dout(dout[1]),
    .valid(valid[1]), .frame_err(ferr[1]), .busy(busy[1]));
  uart_recv #(.CLKS_PER_BIT(16)) u2 (.clk(clk), .rst(rst), .rxd(rxd[2]), .dout(dout[2]),
    .valid(valid[2]), .frame_err(ferr[2]), .busy(busy[2]));

  always #5 clk = ~clk;
  always @(posedge clk) t <= t + 1;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      if (rst) cur[i] = 8'h00;
      else if (ev_v[i][t]) cur[i] = ev_d[i][t];
      cmp($sformatf("valid%0d@%0d", i, t), 32'(valid[i]), 32'(ev_v[i][t]));
      cmp($sformatf("frame_err%0d@%0d", i, t), 32'(ferr[i]), 32'(ev_f[i][t]));
      cmp($sformatf("busy%0d@%0d", i, t), 32'(busy[i]), 32'(ev_b[i][t]));
      cmp($sformatf("dout%0d@%0d", i, t), 32'(dout[i]), 32'(cur[i]));
      if (valid[i] === 1'b1) begin
        vp[i] = vt[i];
        vt[i] = t;
        vd[i] = dout[i];
        vc[i]++;
      end
      if (ferr[i] === 1'b1) fc[i]++;
    end
  endtask

  // Hold line i at v for k cycles, checking all outputs on each falling edge.
  task automatic line(int i, logic v, int k);
    rxd[i] = v;
    repeat (k) begin
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(int i, logic [7:0] d, logic stp, bit jit);
    logic [9:0] f;
    int j[10];
    f = {stp, d, 1'b0};
    for (int k = 0; k < 10; k++) j[k] = jit ? jt[k] : 0;
    for (int k = 0; k < 10; k++) line(i, f[k], cpb[i] + (k < 9 ? j[k + 1] : 0) - j[k]);
  endtask

  task automatic busy_range(int i, int a, int b);
    for (int k = a; k <= b; k++) ev_b[i][k] = 1'b1;
  endtask

  // Line falls at n, so rxd_s falls at t0=n+2; stop bit sampled at t0+9C+H.
  task automatic expect_frame(int i, int n, logic [7:0] d);
    int s;
    s = n + 2 + 9 * cpb[i] + (cpb[i] - 1) / 2;
    busy_range(i, n + 3, s);
    ev_v[i][s + 1] = 1'b1;
    ev_d[i][s + 1] = d;
  endtask

  task automatic expect_break(int i, int n, int r);
    int s;
    s = n + 2 + 9 * cpb[i] + (cpb[i] - 1) / 2;
    busy_range(i, n + 3, r + 2);
    ev_f[i][s + 1] = 1'b1;
  endtask

  initial begin
    int n, c0, c1;
    logic [7:0] d5;
    d5 = 8'h5A;
    line(0, 1'b1, 3);
    rst = 1'b0;
    line(0, 1'b1, 3);
    n = t;
    expect_frame(0, n, 8'hA5);
    send(0, 8'hA5, 1'b1, 0);
    line(0, 1'b1, 5);
    cmp("a5_latency", 32'(vt[0] - n), 32'd12);
    cmp("a5_dout", 32'(vd[0]), 32'hA5);
    n = t;
    expect_frame(0, n, 8'h00);
    expect_frame(0, n + 10, 8'hFF);
    send(0, 8'h00, 1'b1, 0);
    send(0, 8'hFF, 1'b1, 0);
    line(0, 1'b1, 5);
    cmp("b2b_gap", 32'(vt[0] - vp[0]), 32'd10);
    cmp("b2b_dout", 32'(vd[0]), 32'hFF);
    c0 = vc[0];
    c1 = fc[0];
    n = t;
    expect_break(0, n, n + 30);
    send(0, 8'h3C, 1'b0, 0);
    line(0, 1'b0, 20);
    line(0, 1'b1, 4);
    cmp("ferr_no_valid", 32'(vc[0] - c0), 32'd0);
    cmp("ferr_count", 32'(fc[0] - c1), 32'd1);
    cmp("ferr_dout_held", 32'(dout[0]), 32'hFF);
    n = t;
    expect_frame(0, n, 8'h81);
    send(0, 8'h81, 1'b1, 0);
    line(0, 1'b1, 5);
    cmp("after_break_dout", 32'(vd[0]), 32'h81);
    c0 = vc[0];
    n = t;
    busy_range(0, n + 3, n + 5);
    line(0, 1'b0, 1);
    for (int k = 0; k < 5; k++) line(0, d5[k], 1);
    rst = 1'b1;
    line(0, 1'b1, 2);
    rst = 1'b0;
    line(0, 1'b1, 3);
    cmp("reset_no_valid", 32'(vc[0] - c0), 32'd0);
    n = t;
    expect_frame(0, n, 8'hC3);
    send(0, 8'hC3, 1'b1, 0);
    line(0, 1'b1, 5);
    cmp("post_reset_dout", 32'(vd[0]), 32'hC3);
    c0 = vc[1];
    c1 = fc[1];
    n = t;
    busy_range(1, n + 3, n + 3);
    line(1, 1'b0, 1);
    line(1, 1'b1, 15);
    cmp("glitch_no_valid", 32'(vc[1] - c0), 32'd0);
    cmp("glitch_no_ferr", 32'(fc[1] - c1), 32'd0);
    n = t;
    expect_frame(1, n, 8'h96);
    send(1, 8'h96, 1'b1, 0);
    line(1, 1'b1, 5);
    cmp("c4_latency", 32'(vt[1] - n), 32'd40);
    cmp("c4_dout", 32'(vd[1]), 32'h96);
    n = t;
    expect_frame(1, n, 8'h12);
    expect_frame(1, n + 40, 8'hED);
    send(1, 8'h12, 1'b1, 0);
    send(1, 8'hED, 1'b1, 0);
    line(1, 1'b1, 5);
    cmp("c4_b2b_gap", 32'(vt[1] - vp[1]), 32'd40);
    cmp("c4_b2b_dout", 32'(vd[1]), 32'hED);
    n = t;
    expect_frame(2, n, 8'h5A);
    send(2, 8'h5A, 1'b1, 1);
    line(2, 1'b1, 10);
    cmp("jitter_latency", 32'(vt[2] - n), 32'd154);
    cmp("jitter_dout", 32'(vd[2]), 32'h5A);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_recv.md
# uart_recv

Serial-to-parallel UART receiver; the downstream stage of `uart_send`, consuming its `dout` line. Recovers 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) from a single serial line and presents each byte on a parallel bus with a one-cycle `valid` strobe. Bit time is `CLKS_PER_BIT` clocks. The default of 1 matches `uart_send`, which shifts one bit per clock.

## Interface
- `CLKS_PER_BIT`, default 1: clocks per serial bit. Must be ≥1. Mid-bit sample offset is `H = (CLKS_PER_BIT-1)/2` (integer division).
- `clk`  input  1  clock
- `rst`  input  1  reset, asynchronous, active-high
- `rxd`  input  1  serial line; idle high
- `dout`  output  8  last correctly framed byte; holds until the next good frame
- `valid`  output  1  one-cycle pulse; `dout` carries the new byte in the same cycle
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low
- `busy`  output  1  high whenever the state is not IDLE

## Operation
- Input synchronizer:
  - Two flops, `rxd` → `rxd_s`; both reset to 1.
  - All logic below uses `rxd_s` only.
- Bit-timing counter `cyc` (0..CLKS_PER_BIT-1) runs in every non-IDLE state.
  - The cycle on which IDLE first sees `rxd_s`=0 is `cyc`=0 of the start bit.
  - A bit boundary is the wrap from CLKS_PER_BIT-1 to 0.
  - Each bit is sampled when `cyc`==H.
- States:
  - IDLE:
    - `rxd_s`=0 → START.
    - If H==0 the start bit is confirmed on the detection cycle and the state goes directly to DATA.
  - START:
    - At `cyc`==H, `rxd_s`=1 → glitch, return to IDLE with no output.
    - Otherwise → DATA at the bit boundary.
  - DATA:
    - At `cyc`==H, shift `rxd_s` into an 8-bit shift register at the MSB end, shifting right, so the LSB arrives first.
    - 3-bit bit index counts 0..7.
    - After the last cycle of bit 7 → STOP.
  - STOP, at `cyc`==H:
    - `rxd_s`=1: load `dout` from the shift register, pulse `valid`, → IDLE.
    - `rxd_s`=0: pulse `frame_err`, leave `dout` unchanged, → BREAK.
  - BREAK: wait for `rxd_s`=1, then → IDLE. A held-low line (break) never starts a spurious frame.
- Returning to IDLE at the stop-bit sample point means the next start bit is accepted as early as the cycle after the stop-bit sample.
- `valid` and `frame_err` are registered, mutually exclusive, and never high for two consecutive cycles.

## Timing
- Reset values:
  - `dout`=8'h00, `valid`=0, `frame_err`=0, `busy`=0.
  - State IDLE; counters 0; synchronizer flops 1.
- Reset asserted mid-frame: the frame is aborted with no `valid` or `frame_err`. After release the block waits in IDLE for a falling `rxd_s`.
- Latency: `valid` is high at cycle t0 + 9·CLKS_PER_BIT + H + 1, where t0 is the first cycle with `rxd_s`=0.
  - t0 is 2 cycles after `rxd` first falls.
  - For CLKS_PER_BIT=1, `valid` is high 12 cycles after `rxd` first falls.
- Throughput: back-to-back frames with zero idle bits between the stop bit and the next start bit are received without loss for every CLKS_PER_BIT.
- `busy`:
  - Rises the cycle after detection.
  - Falls the cycle after the stop-bit sample, or after the line returns high from BREAK.

## Test plan
- Loopback from `uart_send` (CLKS_PER_BIT=1), data 8'hA5 → exactly one `valid` pulse 12 cycles after `rxd` falls, `dout`=8'hA5, `frame_err` never high.
- Two frames back-to-back (8'h00 then 8'hFF), start of the second immediately after the first stop bit → two `valid` pulses 10 cycles apart (CLKS_PER_BIT=1), with `dout`=8'h00 then 8'hFF.
- Framing error: frame 8'h3C with the stop bit driven 0 and `rxd` held low 20 cycles, then a good frame 8'h81 → a single `frame_err` pulse, no `valid`, `dout` keeps its prior value, `busy` high until the line rises, then 8'h81 received with `valid`.
- Start glitch, CLKS_PER_BIT=4: `rxd` low for 1 cycle only → no `valid`/`frame_err`, `busy` returns to 0 by the start-bit sample point.
- Reset mid-frame: assert `rst` during data bit 3 of 8'h5A → outputs immediately at reset values; the next full frame 8'hC3 is received correctly.
- CLKS_PER_BIT=16, frame 8'h5A with ±3-cycle edge jitter on every bit → `dout`=8'h5A with `valid` at t0 + 144 + 7 + 1.
